// File: rtl/friscv_pkg.sv
// Shared FRISCV definitions: RV32I major opcodes and the immediate format select.
package friscv_pkg;

    localparam logic [6:0] LUI     = 7'b0110111;
    localparam logic [6:0] AUIPC   = 7'b0010111;
    localparam logic [6:0] JAL     = 7'b1101111;
    localparam logic [6:0] JALR    = 7'b1100111;
    localparam logic [6:0] BRANCH  = 7'b1100011;
    localparam logic [6:0] LOAD    = 7'b0000011;
    localparam logic [6:0] STORE   = 7'b0100011;
    localparam logic [6:0] I_ARITH = 7'b0010011;
    localparam logic [6:0] R_ARITH = 7'b0110011;
    localparam logic [6:0] FENCE   = 7'b0001111;
    localparam logic [6:0] SYS     = 7'b1110011;

    // FMT_R doubles as "no immediate": both immediates come out as zero.
    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_R
    } imm_fmt_t;

endpackage

// File: rtl/friscv_imm_gen.sv
// Combinational immediate builder: packs the I/S/B immediate into imm12 and U/J into imm20.
module friscv_imm_gen
    import friscv_pkg::*;
(
    input  logic [31:0] instruction,
    input  imm_fmt_t    fmt,
    output logic [11:0] imm12,
    output logic [19:0] imm20
);

    // The opcode bits are decoded upstream into fmt.
    logic unused_opcode;
    assign unused_opcode = ^instruction[6:0];

    always_comb begin
        imm12 = 12'h000;
        imm20 = 20'h00000;
        case (fmt)
            FMT_I: imm12 = instruction[31:20];
            FMT_S: imm12 = {instruction[31:25], instruction[11:7]};
            FMT_B: imm12 = {instruction[31], instruction[7],
                            instruction[30:25], instruction[11:8]};
            FMT_U: imm20 = instruction[31:12];
            FMT_J: imm20 = {instruction[31], instruction[19:12],
                            instruction[20], instruction[30:21]};
            default: ;
        endcase
    end

endmodule

// File: rtl/friscv_rv32i_decoder.sv
// Registered RV32I decoder: field split, immediates and one-hot dispatch class, 1-cycle latency.
// Define FRISCV_ZICSR_EN to decode the Zicsr SYSTEM instructions and expose csr/zimm.
module friscv_rv32i_decoder
    import friscv_pkg::*;
#(
    parameter int XLEN = 32
)(
    input  logic            aclk,
    input  logic            arst,
    input  logic [XLEN-1:0] instruction,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [4:0]      zimm,
    output logic [11:0]     imm12,
    output logic [19:0]     imm20,
    output logic [11:0]     csr,
    output logic [5:0]      shamt,
    output logic            lui,
    output logic            auipc,
    output logic            jal,
    output logic            jalr,
    output logic            branching,
    output logic            system,
    output logic            processing,
    output logic            inst_error,
    output logic [3:0]      pred,
    output logic [3:0]      succ
);

    logic [6:0]  op;
    logic [2:0]  f3;
    imm_fmt_t    fmt;
    logic [11:0] imm12_d;
    logic [19:0] imm20_d;
    logic [11:0] csr_d;
    logic [4:0]  zimm_d;
    logic        c_lui, c_auipc, c_jal, c_jalr, c_branch, c_system, c_proc;
    logic        err;

    assign op = instruction[6:0];
    assign f3 = instruction[14:12];

    friscv_imm_gen u_imm_gen (
        .instruction (instruction[31:0]),
        .fmt         (fmt),
        .imm12       (imm12_d),
        .imm20       (imm20_d)
    );

`ifdef FRISCV_ZICSR_EN
    assign csr_d  = instruction[31:20];
    assign zimm_d = instruction[19:15];
`else
    assign csr_d  = 12'h000;
    assign zimm_d = 5'h00;
`endif

    always_comb begin
        c_lui    = 1'b0;
        c_auipc  = 1'b0;
        c_jal    = 1'b0;
        c_jalr   = 1'b0;
        c_branch = 1'b0;
        c_system = 1'b0;
        c_proc   = 1'b0;
        err      = 1'b0;
        fmt      = FMT_R;
        case (op)
            LUI:     begin c_lui    = 1'b1; fmt = FMT_U; end
            AUIPC:   begin c_auipc  = 1'b1; fmt = FMT_U; end
            JAL:     begin c_jal    = 1'b1; fmt = FMT_J; end
            JALR:    begin c_jalr   = 1'b1; fmt = FMT_I; end
            BRANCH:  begin c_branch = 1'b1; fmt = FMT_B; end
            LOAD:    begin c_proc   = 1'b1; fmt = FMT_I; end
            STORE:   begin c_proc   = 1'b1; fmt = FMT_S; end
            R_ARITH: c_proc = 1'b1;
            FENCE:   c_system = 1'b1;
            I_ARITH: begin
                fmt = FMT_I;
                // RV32I shifts only take a 5-bit shamt; bit 25 set is an RV64 encoding.
                if ((f3 == 3'b001 || f3 == 3'b101) && instruction[25])
                    err = 1'b1;
                else
                    c_proc = 1'b1;
            end
            SYS: begin
                fmt = FMT_I;
                if (f3 == 3'b000)
                    c_system = 1'b1;
`ifdef FRISCV_ZICSR_EN
                else if (f3 != 3'b100)
                    c_system = 1'b1;
`endif
                else
                    err = 1'b1;
            end
            default: err = 1'b1;
        endcase
        if (instruction[1:0] != 2'b11)
            err = 1'b1;
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            opcode     <= '0;
            funct3     <= '0;
            funct7     <= '0;
            rs1        <= '0;
            rs2        <= '0;
            rd         <= '0;
            zimm       <= '0;
            imm12      <= '0;
            imm20      <= '0;
            csr        <= '0;
            shamt      <= '0;
            pred       <= '0;
            succ       <= '0;
            lui        <= 1'b0;
            auipc      <= 1'b0;
            jal        <= 1'b0;
            jalr       <= 1'b0;
            branching  <= 1'b0;
            system     <= 1'b0;
            processing <= 1'b0;
            inst_error <= 1'b0;
        end else begin
            opcode     <= op;
            funct3     <= f3;
            funct7     <= instruction[31:25];
            rs1        <= instruction[19:15];
            rs2        <= instruction[24:20];
            rd         <= instruction[11:7];
            zimm       <= zimm_d;
            imm12      <= imm12_d;
            imm20      <= imm20_d;
            csr        <= csr_d;
            shamt      <= instruction[25:20];
            pred       <= instruction[27:24];
            succ       <= instruction[23:20];
            // An error masks every class flag so the dispatch stays one-hot.
            lui        <= c_lui    & ~err;
            auipc      <= c_auipc  & ~err;
            jal        <= c_jal    & ~err;
            jalr       <= c_jalr   & ~err;
            branching  <= c_branch & ~err;
            system     <= c_system & ~err;
            processing <= c_proc   & ~err;
            inst_error <= err;
        end
    end

endmodule

// File: tb/tb_friscv_rv32i_decoder.sv
// Directed bench for friscv_rv32i_decoder; expectations hand-decoded from the RV32I encodings.
module tb_friscv_rv32i_decoder;

    logic        aclk = 1'b0;
    logic        arst;
    logic [31:0] instruction;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1, rs2, rd, zimm;
    logic [11:0] imm12, csr;
    logic [19:0] imm20;
    logic [5:0]  shamt;
    logic        lui, auipc, jal, jalr, branching, system, processing, inst_error;
    logic [3:0]  pred, succ;

    int errors = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    friscv_rv32i_decoder #(.XLEN(32)) dut (
        .aclk        (aclk),
        .arst        (arst),
        .instruction (instruction),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .zimm        (zimm),
        .imm12       (imm12),
        .imm20       (imm20),
        .csr         (csr),
        .shamt       (shamt),
        .lui         (lui),
        .auipc       (auipc),
        .jal         (jal),
        .jalr        (jalr),
        .branching   (branching),
        .system      (system),
        .processing  (processing),
        .inst_error  (inst_error),
        .pred        (pred),
        .succ        (succ)
    );

    // Flag order: lui auipc jal jalr branching system processing inst_error
    localparam logic [7:0] F_LUI  = 8'b1000_0000;
    localparam logic [7:0] F_AUI  = 8'b0100_0000;
    localparam logic [7:0] F_JAL  = 8'b0010_0000;
    localparam logic [7:0] F_BR   = 8'b0000_1000;
    localparam logic [7:0] F_SYS  = 8'b0000_0100;
    localparam logic [7:0] F_PROC = 8'b0000_0010;
    localparam logic [7:0] F_ERR  = 8'b0000_0001;

    function automatic logic [7:0] flags();
        return {lui, auipc, jal, jalr, branching, system, processing, inst_error};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [31:0] w);
        @(negedge aclk);
        instruction = w;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        arst = 1'b1;
        instruction = 32'h00C12403;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_flags", {24'h0, flags()}, 32'h0);
        chk("rst_opcode", {25'h0, opcode}, 32'h0);
        chk("rst_imm12", {20'h0, imm12}, 32'h0);
        chk("rst_rd_rs1", {22'h0, rd, rs1}, 32'h0);

        @(negedge aclk);
        arst = 1'b0;

        apply(32'h00C12403);
        chk("lw_opcode", {25'h0, opcode}, 32'h03);
        chk("lw_rd", {27'h0, rd}, 32'd8);
        chk("lw_rs1", {27'h0, rs1}, 32'd2);
        chk("lw_funct3", {29'h0, funct3}, 32'd2);
        chk("lw_imm12", {20'h0, imm12}, 32'h00C);
        chk("lw_flags", {24'h0, flags()}, {24'h0, F_PROC});

        apply(32'h0080006F);
        chk("jal_flags", {24'h0, flags()}, {24'h0, F_JAL});
        chk("jal_rd", {27'h0, rd}, 32'd0);
        chk("jal_imm20", {12'h0, imm20}, 32'h00004);
        chk("jal_imm12", {20'h0, imm12}, 32'h0);

        apply(32'h00208463);
        chk("beq_flags", {24'h0, flags()}, {24'h0, F_BR});
        chk("beq_imm12", {20'h0, imm12}, 32'h004);
        chk("beq_rs2", {27'h0, rs2}, 32'd2);

        apply(32'h00112623);
        chk("sw_flags", {24'h0, flags()}, {24'h0, F_PROC});
        chk("sw_imm12", {20'h0, imm12}, 32'h00C);

        apply(32'h30029073);
        chk("csrrw_imm12", {20'h0, imm12}, 32'h300);
`ifdef FRISCV_ZICSR_EN
        chk("csrrw_flags", {24'h0, flags()}, {24'h0, F_SYS});
        chk("csrrw_csr", {20'h0, csr}, 32'h300);
        chk("csrrw_zimm", {27'h0, zimm}, 32'd5);
`else
        chk("csrrw_flags", {24'h0, flags()}, {24'h0, F_ERR});
        chk("csrrw_csr", {20'h0, csr}, 32'h0);
        chk("csrrw_zimm", {27'h0, zimm}, 32'd0);
`endif

        apply(32'h00000073);
        chk("ecall_flags", {24'h0, flags()}, {24'h0, F_SYS});

        apply(32'h0FF0000F);
        chk("fence_flags", {24'h0, flags()}, {24'h0, F_SYS});
        chk("fence_pred_succ", {24'h0, pred, succ}, 32'hFF);

        apply(32'h00000000);
        chk("zero_flags", {24'h0, flags()}, {24'h0, F_ERR});

        apply(32'h0200D093);
        chk("shamt5_flags", {24'h0, flags()}, {24'h0, F_ERR});
        chk("shamt5_shamt", {26'h0, shamt}, 32'h20);
        chk("shamt5_funct3", {29'h0, funct3}, 32'd5);

        apply(32'h0010D093);
        chk("srli_flags", {24'h0, flags()}, {24'h0, F_PROC});

        apply(32'h123450B7);
        chk("lui_flags", {24'h0, flags()}, {24'h0, F_LUI});
        chk("lui_imm20", {12'h0, imm20}, 32'h12345);
        chk("lui_rd", {27'h0, rd}, 32'd1);
        @(negedge aclk);
        instruction = 32'h00001117;
        @(posedge aclk);
        #1;
        chk("auipc_flags", {24'h0, flags()}, {24'h0, F_AUI});
        chk("auipc_imm20", {12'h0, imm20}, 32'h00001);
        chk("auipc_rd", {27'h0, rd}, 32'd2);

        // Asynchronous clear between edges, then first edge after release.
        #2;
        arst = 1'b1;
        #1;
        chk("async_rst_flags", {24'h0, flags()}, 32'h0);
        chk("async_rst_imm20", {12'h0, imm20}, 32'h0);
        @(negedge aclk);
        instruction = 32'h123450B7;
        arst = 1'b0;
        @(posedge aclk);
        #1;
        chk("post_rst_flags", {24'h0, flags()}, {24'h0, F_LUI});
        chk("post_rst_imm20", {12'h0, imm20}, 32'h12345);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
